disp_share_arb: RTL and testbench

//  Shares the single 4-digit seven-segment display between two requesters (client A, client B).

---
 rtl/disp_share_arb.sv | 114 +++++++++++
 tb/tb_disp_share_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/disp_share_arb.sv
// Round-robin owner of the shared 4-digit display with a minimum hold time between contested handovers.
// Outputs are registered from the next state so grant, data and switch pulse move on the same edge.
module disp_share_arb #(
  parameter int          DIV        = 50_000,
  parameter int          HOLD_TICKS = 2_000,
  parameter logic [15:0] IDLE_HEX   = 16'h0000,
  parameter logic [3:0]  IDLE_DP    = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] hex_a,
  input  logic [3:0]  dp_a,
  input  logic        req_b,
  input  logic [15:0] hex_b,
  input  logic [3:0]  dp_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        switch_p,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [3:0]  dp_out
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t         state, next_state;
  logic           last_b;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [HW-1:0]  hold_cnt;
  logic           expired;

  assign tick    = (presc == PW'(DIV - 1));
  assign expired = (hold_cnt == HW'(HOLD_TICKS));

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_a && req_b)  next_state = last_b ? GNT_A : GNT_B;
        else if (req_a)      next_state = GNT_A;
        else if (req_b)      next_state = GNT_B;
        else                 next_state = IDLE;
      end
      // Release is always immediate; only a contested takeover waits for expiry.
      GNT_A: begin
        if (!req_a)                next_state = req_b ? GNT_B : IDLE;
        else if (req_b && expired) next_state = GNT_B;
        else                       next_state = GNT_A;
      end
      GNT_B: begin
        if (!req_b)                next_state = req_a ? GNT_A : IDLE;
        else if (req_a && expired) next_state = GNT_A;
        else                       next_state = GNT_B;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      hold_cnt <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      switch_p <= 1'b0;
      {hex3, hex2, hex1, hex0} <= IDLE_HEX;
      dp_out   <= IDLE_DP;
    end else begin
      state    <= next_state;
      switch_p <= (next_state != state);
      if (next_state != state && next_state != IDLE) begin
        hold_cnt <= '0;
        last_b   <= (next_state == GNT_B);
      end else if (state != IDLE && tick && !expired) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      gnt_a <= (next_state == GNT_A);
      gnt_b <= (next_state == GNT_B);
      unique case (next_state)
        GNT_A: begin
          {hex3, hex2, hex1, hex0} <= hex_a;
          dp_out <= dp_a;
        end
        GNT_B: begin
          {hex3, hex2, hex1, hex0} <= hex_b;
          dp_out <= dp_b;
        end
        default: begin
          {hex3, hex2, hex1, hex0} <= IDLE_HEX;
          dp_out <= IDLE_DP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_share_arb.sv
// Scoreboard bench for disp_share_arb: a per-edge ownership model pushes expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_disp_share_arb;

  localparam int          DIV  = 4;
  localparam int          HOLD = 3;
  localparam logic [15:0] IHEX = 16'h0000;
  localparam logic [3:0]  IDP  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [15:0] hex_a, hex_b;
  logic [3:0]  dp_a, dp_b;
  logic        gnt_a, gnt_b, switch_p;
  logic [3:0]  hex3, hex2, hex1, hex0, dp_out;

  disp_share_arb #(.DIV(DIV), .HOLD_TICKS(HOLD), .IDLE_HEX(IHEX), .IDLE_DP(IDP)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .hex_a(hex_a), .dp_a(dp_a),
    .req_b(req_b), .hex_b(hex_b), .dp_b(dp_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .switch_p(switch_p),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [22:0] exp_q[$];
  bit          running = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int m_owner, m_last, m_held, m_k;

  function automatic logic [22:0] actual_word();
    return {gnt_a, gnt_b, switch_p, hex3, hex2, hex1, hex0, dp_out};
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_held  = 0;
    m_k     = 0;
  endtask

  task automatic drive(input bit ra, input bit rb, input logic [15:0] ha, input logic [15:0] hb,
                       input logic [3:0] da, input logic [3:0] db);
    int  nxt;
    bit  tick, expired, mine, other;
    logic [15:0] eh;
    logic [3:0]  ed;
    @(negedge clk);
    reset = 1'b0;
    req_a = ra; req_b = rb; hex_a = ha; hex_b = hb; dp_a = da; dp_b = db;
    tick    = ((m_k % DIV) == DIV - 1);
    expired = (m_held >= HOLD);
    nxt     = m_owner;
    if (m_owner == 0) begin
      if (ra && rb)  nxt = 3 - m_last;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
    end else begin
      mine  = (m_owner == 1) ? ra : rb;
      other = (m_owner == 1) ? rb : ra;
      if (!mine)                nxt = other ? 3 - m_owner : 0;
      else if (other && expired) nxt = 3 - m_owner;
    end
    if (nxt != m_owner && nxt != 0) begin
      m_held = 0;
      m_last = nxt;
    end else if (m_owner != 0 && tick) begin
      m_held++;
    end
    eh = (nxt == 1) ? ha : (nxt == 2) ? hb : IHEX;
    ed = (nxt == 1) ? da : (nxt == 2) ? db : IDP;
    exp_q.push_back({(nxt == 1), (nxt == 2), (nxt != m_owner), eh, ed});
    m_owner = nxt;
    m_k++;
    running = 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (actual_word() !== {3'b000, IHEX, IDP}) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", actual_word(), {3'b000, IHEX, IDP});
    end
    model_reset();
    exp_q.push_back({3'b000, IHEX, IDP});
  endtask

  function automatic logic [15:0] r16();
    return 16'($urandom_range(0, 65535));
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  always @(posedge clk) begin
    logic [22:0] e;
    #1;
    if (running) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty at %0t got=%h want=<entry>", $time, actual_word());
      end else begin
        e = exp_q.pop_front();
        if (actual_word() !== e) begin
          errors++;
          $display("FAIL outputs at %0t got=%h want=%h", $time, actual_word(), e);
        end
      end
      checks++;
      if (gnt_a && gnt_b) begin
        errors++;
        $display("FAIL gnt_excl at %0t got=11 want=not both", $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ra, rb;
    reset = 1'b1;
    req_a = 0; req_b = 0; hex_a = '0; hex_b = '0; dp_a = '0; dp_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (actual_word() !== {3'b000, IHEX, IDP}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", actual_word(), {3'b000, IHEX, IDP});
    end

    // Idle with changing client data: display stays on the idle pattern.
    for (int i = 0; i < 8; i++) drive(0, 0, r16(), r16(), r4(), r4());

    // Single client A, then data change follows one cycle later.
    for (int i = 0; i < 5; i++) drive(1, 0, 16'h1234, r16(), 4'b1110, r4());
    for (int i = 0; i < 3; i++) drive(1, 0, 16'hBEEF, r16(), 4'b0101, r4());
    drive(0, 0, r16(), r16(), r4(), r4());

    // Contest from reset: A first, hand to B after the hold, then alternation.
    pulse_reset();
    for (int i = 0; i < 60; i++) drive(1, 1, r16(), r16(), r4(), r4());

    // A owns, B asks, A releases before expiry.
    pulse_reset();
    for (int i = 0; i < 2; i++) drive(1, 0, r16(), r16(), r4(), r4());
    for (int i = 0; i < 3; i++) drive(1, 1, r16(), r16(), r4(), r4());
    for (int i = 0; i < 3; i++) drive(0, 1, r16(), r16(), r4(), r4());

    // Reset while B owns, then both request: A must win.
    for (int i = 0; i < 2; i++) drive(1, 1, r16(), r16(), r4(), r4());
    pulse_reset();
    for (int i = 0; i < 10; i++) drive(1, 1, r16(), r16(), r4(), r4());

    // Randomised request levels with occasional resets.
    ra = 0; rb = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) ra = ~ra;
      if ($urandom_range(0, 9) == 0) rb = ~rb;
      if ($urandom_range(0, 299) == 0) pulse_reset();
      drive(ra, rb, r16(), r16(), r4(), r4());
    end
    drive(0, 0, r16(), r16(), r4(), r4());

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
